// File: rtl/tanh_pkg.sv
// Shared types and W-dependent constants for the shift-and-add tanh approximation.
// No logic; no latency; no flow control.
// Thresholds are in input LSBs (Q3.(W-3)); offsets and saturation are in output LSBs (Q1.(W-1)).
package tanh_pkg;

    typedef enum logic [1:0] {SEG0, SEG1, SEG2, SEG3} seg_e;

    // |x| < 0.5
    function automatic int unsigned th_half(input int unsigned w);
        return 32'd1 << (w - 4);
    endfunction

    // |x| < 1.0, also the seg1 offset of 0.25
    function automatic int unsigned th_one(input int unsigned w);
        return 32'd1 << (w - 3);
    endfunction

    // |x| < 2.0, also the seg2 offset of 0.5
    function automatic int unsigned th_two(input int unsigned w);
        return 32'd1 << (w - 2);
    endfunction

    function automatic int unsigned m_max(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/tanh_pwl_lane.sv
// Per-lane combinational logic: sign/|x|/segment decode (stage 1) and magnitude (stage 2).
// Zero latency; the caller registers every output.
// No flow control; the enclosing pipeline stalls the registers around it.
module tanh_pwl_lane
    import tanh_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] a_q,
    input  seg_e         seg_q,
    output logic         s,
    output logic [W-1:0] a,
    output seg_e         seg,
    output logic [W-1:0] m
);

    localparam logic [W-1:0] T_HALF = W'(th_half(W));
    localparam logic [W-1:0] T_ONE  = W'(th_one(W));
    localparam logic [W-1:0] T_TWO  = W'(th_two(W));
    localparam logic [W-1:0] M_MAX  = W'(m_max(W));

    // The most negative input negates to itself, 2^(W-1) unsigned, which lands in SEG3.
    always_comb begin
        s   = x[W-1];
        a   = s ? (~x + W'(1)) : x;
        seg = SEG3;
        if (a < T_HALF)
            seg = SEG0;
        else if (a < T_ONE)
            seg = SEG1;
        else if (a < T_TWO)
            seg = SEG2;
    end

    always_comb begin
        m = M_MAX;
        case (seg_q)
            SEG0:    m = a_q << 2;
            SEG1:    m = (a_q << 1) + T_ONE;
            SEG2:    m = a_q + T_TWO;
            default: m = M_MAX;
        endcase
    end

endmodule

// File: rtl/tanh_pwl_stream.sv
// Streaming LANES-wide PWL tanh, Q3.(W-3) in, Q1.(W-1) out; optional TANH_SAT_CNT_EN saturation counter.
// Latency 3 cycles, 1 beat/cycle throughput.
// Whole pipeline stalls while out_valid & ~out_ready; in_ready is the shared advance enable.
module tanh_pwl_stream
    import tanh_pkg::*;
#(
    parameter int W     = 8,
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] In,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] Out1
`ifdef TANH_SAT_CNT_EN
    ,
    output logic [15:0]        sat_cnt
`endif
);

    logic         en;
    logic         v1, v2;

    logic         s_d   [LANES];
    logic [W-1:0] a_d   [LANES];
    seg_e         seg_d [LANES];
    logic [W-1:0] m_d   [LANES];

    logic         s1    [LANES];
    logic [W-1:0] a1    [LANES];
    seg_e         seg1  [LANES];
    logic         s2    [LANES];
    logic [W-1:0] m2    [LANES];
    logic [W-1:0] res   [LANES];

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tanh_pwl_lane #(.W(W)) u_lane (
            .x     (In[i*W +: W]),
            .a_q   (a1[i]),
            .seg_q (seg1[i]),
            .s     (s_d[i]),
            .a     (a_d[i]),
            .seg   (seg_d[i]),
            .m     (m_d[i])
        );
        assign Out1[i*W +: W] = res[i];
    end

    // Data registers load on every enabled cycle; only the valids qualify them.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1[i]   <= 1'b0;
                a1[i]   <= '0;
                seg1[i] <= SEG0;
                s2[i]   <= 1'b0;
                m2[i]   <= '0;
                res[i]  <= '0;
            end
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            for (int i = 0; i < LANES; i++) begin
                s1[i]   <= s_d[i];
                a1[i]   <= a_d[i];
                seg1[i] <= seg_d[i];
                s2[i]   <= s1[i];
                m2[i]   <= m_d[i];
                res[i]  <= s2[i] ? (~m2[i] + W'(1)) : m2[i];
            end
        end
    end

`ifdef TANH_SAT_CNT_EN
    logic [LANES-1:0] sat2, sat3;
    logic [15:0]      sat_q;

    assign sat_cnt = sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat2  <= '0;
            sat3  <= '0;
            sat_q <= '0;
        end else begin
            if (en) begin
                for (int i = 0; i < LANES; i++)
                    sat2[i] <= (seg1[i] == SEG3);
                sat3 <= sat2;
            end
            // Sticky at all-ones rather than wrapping.
            if (out_valid && out_ready && (|sat3) && (sat_q != 16'hFFFF))
                sat_q <= sat_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tanh_pwl_stream.sv
// Bench for tanh_pwl_stream: vector table, scoreboarded streaming with backpressure, reset, 4-lane beat.
// Saturation-counter checks are built only with TANH_SAT_CNT_EN.
module tb_tanh_pwl_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  x_in, y_out;
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0] x_in4, y_out4;
`ifdef TANH_SAT_CNT_EN
    logic [15:0] sat_cnt, sat_cnt4;
`endif

    tanh_pwl_stream #(.W(8), .LANES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .In(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .Out1(y_out)
`ifdef TANH_SAT_CNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    tanh_pwl_stream #(.W(8), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .In(x_in4),
        .out_valid(out_valid4), .out_ready(out_ready4), .Out1(y_out4)
`ifdef TANH_SAT_CNT_EN
        , .sat_cnt(sat_cnt4)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference written as real-valued line segments of tanh, not as shifts.
    function automatic logic [7:0] ref_tanh(input logic [7:0] x);
        real ax, f;
        bit  neg;
        int  r;
        ax  = $itor($signed(x)) / 32.0;
        neg = (ax < 0.0);
        if (neg) ax = -ax;
        if (ax < 0.5)      f = ax;
        else if (ax < 1.0) f = ax / 2.0 + 0.25;
        else if (ax < 2.0) f = ax / 4.0 + 0.5;
        else               f = 127.0 / 128.0;
        r = $rtoi(f * 128.0);
        if (neg) r = -r;
        return r[7:0];
    endfunction

    typedef struct {
        logic [7:0] exp;
        int         cyc;
    } sb_t;

    sb_t        q[$];
    sb_t        e;
    bit         chk_lat = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] held;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_hold_data", y_out, held);
                check("stall_hold_valid", out_valid, 1);
            end
            stalled = out_valid && !out_ready;
            held    = y_out;
            if (out_valid && !out_ready)
                check("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("spurious_beat");
                end else begin
                    e = q.pop_front();
                    check("sb_data", y_out, e.exp);
                    if (chk_lat) check("sb_latency", cyc - e.cyc, 3);
                end
            end
            if (in_valid && in_ready)
                q.push_back('{exp: ref_tanh(x_in), cyc: cyc});
        end
    end

    task automatic send(input logic [7:0] x);
        bit acc;
        int g;
        in_valid = 1'b1;
        x_in     = x;
        g        = 0;
        do begin
            @(negedge clk) acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 50);
        if (!acc) fail_now("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
    } vec_t;

    vec_t tv[9];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv[0] = '{8'h08, 8'h20};
        tv[1] = '{8'h10, 8'h40};
        tv[2] = '{8'h20, 8'h60};
        tv[3] = '{8'h30, 8'h70};
        tv[4] = '{8'h40, 8'h7F};
        tv[5] = '{8'hF0, 8'hC0};
        tv[6] = '{8'h80, 8'h81};
        tv[7] = '{8'h7F, 8'h7F};
        tv[8] = '{8'h1F, 8'h5E};

        rst        = 1'b1;
        in_valid   = 1'b0;
        x_in       = 8'h00;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        x_in4      = '0;
        out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out1", y_out, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid4", out_valid4, 0);
        check("rst_out1_4", y_out4, 0);
`ifdef TANH_SAT_CNT_EN
        check("rst_sat_cnt", sat_cnt, 0);
`endif
        @(posedge clk);
        #1;

        chk_lat = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(tv[i].x);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 10);
            check($sformatf("vec_%0d_x%02h", i, tv[i].x), y_out, tv[i].y);
            check($sformatf("vec_%0d_lat", i), n, 3);
            drain();
        end

        // Ten back-to-back beats with a four-cycle downstream stall mid-stream.
        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(8'(i * 29 - 100));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send(8'(8'h30 + i));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out1", y_out, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Four lanes in one beat.
        x_in4     = {8'h00, 8'hF0, 8'h08, 8'h40};
        in_valid4 = 1'b1;
        @(negedge clk);
        check("lane4_in_ready", in_ready4, 1);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid4 && n < 10);
        check("lane4_out1", y_out4, {8'h00, 8'hC0, 8'h20, 8'h7F});
        check("lane4_lat", n, 3);
        @(posedge clk);
        #1;

`ifdef TANH_SAT_CNT_EN
        do_reset();
        @(negedge clk);
        check("sat_after_rst", sat_cnt, 0);
        @(posedge clk);
        #1;
        send(8'h40);
        send(8'h7F);
        send(8'h80);
        send(8'h10);
        send(8'h00);
        drain();
        check("sat_three", sat_cnt, 3);

        // Walk the counter up to 0xFFFC with a continuous saturating stream.
        x_in     = 8'h40;
        in_valid = 1'b1;
        repeat (65529) @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("sat_near_max", sat_cnt, 16'hFFFC);
        for (int i = 0; i < 5; i++) send(8'hC0);
        drain();
        check("sat_sticky", sat_cnt, 16'hFFFF);
        send(8'h40);
        drain();
        check("sat_sticky_again", sat_cnt, 16'hFFFF);

        do_reset();
        @(negedge clk);
        check("sat_rst_clear", sat_cnt, 0);
        @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
